mem_rssb_ram: RTL and testbench
===============================

# mem_rssb_ram

Parametrised, memory-mapped data RAM for the RSSB datapath. It extends the fixed four-word window to DEPTH words of WIDTH bits, each with a per-word reset value. Access is through a request/done handshake supporting read, write and an atomic reverse-subtract-and-store (RSSB) operation that also reports borrow. It sits between the control sequencer and the register file, selected by the top address bit.

## Interface
- WIDTH, 8, data and address width in bits.
- DEPTH, 4, number of words; power of two, 2..2^(WIDTH-1).
- INIT, `mem_rssb_pkg::MEM_INIT_DEFAULT`, DEPTH*WIDTH-bit reset image; word i = INIT[i*WIDTH +: WIDTH].
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- op  input  2  operation, `op_e`: OP_READ=00, OP_WRITE=01, OP_RSSB=10, 11 reserved.
- address  input  WIDTH  byte address; window hit when address[WIDTH-1]=1.
- in  input  WIDTH  write data (OP_WRITE) or accumulator operand (OP_RSSB).
- out  output  WIDTH  registered result: read word or RSSB difference.
- borrow  output  1  registered; 1 when last RSSB operand > stored word.
- hit  output  1  registered; 1 when last completed request fell in the window.
- busy  output  1  1 whenever state ≠ IDLE (combinational from state).
- done  output  1  one-cycle completion pulse.

## Operation
- Index = address[AW-1:0], AW = $clog2(DEPTH). Bits [WIDTH-2:AW] are ignored, so upper addresses alias.
- FSM states: IDLE, ACCESS, EXEC.
- IDLE with req=1: latch op, address and in, then go to ACCESS. With req=0: stay in IDLE.
- ACCESS behaviour by op:
  - OP_READ: out←mem[idx], go to IDLE.
  - OP_WRITE: mem[idx]←in, out unchanged, go to IDLE.
  - OP_RSSB: tmp←mem[idx], go to EXEC.
- EXEC: diff = tmp − in (modulo 2^WIDTH); mem[idx]←diff; out←diff; borrow←(in > tmp), unsigned compare; go to IDLE.
- Miss (address[WIDTH-1]=0) or reserved op:
  - Completes from ACCESS with out←0 and hit←0.
  - No memory write; borrow unchanged.
- done←1 on the edge that returns to IDLE. hit is updated on that same edge. borrow is updated only by an RSSB hit.
- req while busy is ignored (not queued).
- No read or write ports bypass the handshake.

## Timing
- Reset: every word←INIT word, state←IDLE, out=0, borrow=0, hit=0, done=0, busy=0.
- Reset mid-operation aborts it: no writeback, no done pulse, and words revert to INIT.
- Latency from the accepting edge (cycle 0):
  - READ, WRITE, miss, reserved: done high in cycle 1.
  - RSSB hit: done high in cycle 2.
- The write takes effect on the done edge; a READ accepted afterwards returns the new value.
- Back-to-back: a req held high during the done cycle is accepted on that edge. This gives a throughput of one READ/WRITE per 2 cycles and one RSSB per 3 cycles.
- done is never high for two consecutive cycles.

## Structure
- Package `mem_rssb_pkg` holds:
  - `op_e` enum.
  - FSM state enum `state_e`.
  - `MEM_INIT_DEFAULT` = {8'h04, 8'h08, 8'h02, 8'h01} (word3..word0) for WIDTH=8, DEPTH=4. Other configurations must override INIT.
- Sub-module `mem_rssb_word`: one WIDTH-bit register with synchronous reset to its INIT slice and a write enable. It is instantiated DEPTH times by a generate loop, with a one-hot write-enable decode from idx.
- Read mux, subtractor and FSM live in the top module.

## Test plan
- Reset, then READ at 0x80, 0x81, 0x82, 0x83 → out = 01, 02, 08, 04; hit=1; borrow=0; each done one cycle after accept.
- WRITE 0x82←0x55, then READ 0x82 → 0x55; READ 0x86 (alias) → 0x55; word 3 is still 0x04.
- RSSB 0x81 with in=0x05 (word=0x02) → done at cycle 2, out=0xFD, borrow=1, subsequent READ 0x81=0xFD. RSSB 0x80 with in=0x01 → out=0x00, borrow=0.
- WRITE 0x03←0xAA (miss) → done at cycle 1, hit=0, out=0x00, all four words unchanged. op=11 at 0x80 → hit=0, no write.
- req pulsed at cycles 1 and 2 of an RSSB is ignored (single done). req held high continuously with READs → done every 2nd cycle, never consecutive.
- Assert rst during EXEC of RSSB 0x82 (in=0x01) → no done; word 2 reads 0x08 after reset; out=0, borrow=0.

Source files
------------

// File: rtl/mem_rssb_pkg.sv
// rtl/mem_rssb_pkg.sv - shared types and default reset image for the RSSB data RAM
package mem_rssb_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_RSSB  = 2'b10
   } op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      EXEC   = 2'b10
   } state_e;

   // word3..word0 for the default WIDTH=8, DEPTH=4 configuration
   localparam logic [31:0] MEM_INIT_DEFAULT = {8'h04, 8'h08, 8'h02, 8'h01};

endpackage

// File: rtl/mem_rssb_ram_if.sv
// rtl/mem_rssb_ram_if.sv - request/done handshake bundle for the RSSB data RAM
interface mem_rssb_ram_if #(
   parameter int WIDTH = 8
);
   import mem_rssb_pkg::*;

   logic             req;
   op_e              op;
   logic [WIDTH-1:0] address;
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;
   logic             borrow;
   logic             hit;
   logic             busy;
   logic             done;

   modport master (
      output req, op, address, in,
      input  out, borrow, hit, busy, done
   );

   modport slave (
      input  req, op, address, in,
      output out, borrow, hit, busy, done
   );

endinterface

// File: rtl/mem_rssb_word.sv
// rtl/mem_rssb_word.sv - one storage word with synchronous reset to its initial value
module mem_rssb_word #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= INIT_VAL;
      end else if (we) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_rssb_ram.sv
// rtl/mem_rssb_ram.sv - DEPTH-word data RAM with read, write and reverse-subtract-and-store
module mem_rssb_ram
   import mem_rssb_pkg::*;
#(
   parameter int                     WIDTH = 8,
   parameter int                     DEPTH = 4,
   parameter logic [DEPTH*WIDTH-1:0] INIT  = MEM_INIT_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   mem_rssb_ram_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   state_e           state, state_n;
   op_e              op_q;
   logic [AW-1:0]    idx_q;
   logic             win_q;
   logic [WIDTH-1:0] in_q, tmp_q;
   logic [WIDTH-1:0] out_q, out_n;
   logic             borrow_q, borrow_n;
   logic             hit_q, hit_n;
   logic             done_q, done_n;
   logic             load_in, load_tmp, we_any;
   logic [WIDTH-1:0] wdata, diff, rdata;
   logic [WIDTH-1:0] words [DEPTH];
   logic [DEPTH-1:0] we;
   logic             unused_addr;

   // only the window bit and the index bits matter; the rest alias
   assign unused_addr = ^bus.address;

   assign rdata = words[idx_q];
   assign diff  = tmp_q - in_q;

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      assign we[i] = we_any && (idx_q == AW'(i));
      mem_rssb_word #(
         .WIDTH    (WIDTH),
         .INIT_VAL (INIT[i*WIDTH +: WIDTH])
      ) u_word (
         .clk (clk),
         .rst (rst),
         .we  (we[i]),
         .d   (wdata),
         .q   (words[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      load_in  = 1'b0;
      load_tmp = 1'b0;
      we_any   = 1'b0;
      wdata    = diff;
      out_n    = out_q;
      borrow_n = borrow_q;
      hit_n    = hit_q;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req) begin
               load_in = 1'b1;
               state_n = ACCESS;
            end
         end
         ACCESS: begin
            state_n = IDLE;
            done_n  = 1'b1;
            hit_n   = 1'b1;
            if (!win_q) begin
               out_n = '0;
               hit_n = 1'b0;
            end else begin
               case (op_q)
                  OP_READ:  out_n = rdata;
                  OP_WRITE: begin
                     we_any = 1'b1;
                     wdata  = in_q;
                  end
                  OP_RSSB: begin
                     // hit is only published on the completing edge
                     load_tmp = 1'b1;
                     state_n  = EXEC;
                     done_n   = 1'b0;
                     hit_n    = hit_q;
                  end
                  default: begin
                     out_n = '0;
                     hit_n = 1'b0;
                  end
               endcase
            end
         end
         EXEC: begin
            we_any   = 1'b1;
            wdata    = diff;
            out_n    = diff;
            borrow_n = (in_q > tmp_q);
            hit_n    = 1'b1;
            done_n   = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= OP_READ;
         idx_q    <= '0;
         win_q    <= 1'b0;
         in_q     <= '0;
         tmp_q    <= '0;
         out_q    <= '0;
         borrow_q <= 1'b0;
         hit_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         if (load_in) begin
            op_q  <= bus.op;
            idx_q <= bus.address[AW-1:0];
            win_q <= bus.address[WIDTH-1];
            in_q  <= bus.in;
         end
         if (load_tmp) begin
            tmp_q <= rdata;
         end
         out_q    <= out_n;
         borrow_q <= borrow_n;
         hit_q    <= hit_n;
         done_q   <= done_n;
      end
   end

   assign bus.out    = out_q;
   assign bus.borrow = borrow_q;
   assign bus.hit    = hit_q;
   assign bus.done   = done_q;
   assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_rssb_ram.sv
// tb/tb_mem_rssb_ram.sv - table-driven scoreboard bench for mem_rssb_ram
module tb_mem_rssb_ram;
   import mem_rssb_pkg::*;

   typedef struct {
      op_e        op;
      logic [7:0] addr;
      logic [7:0] din;
      logic [7:0] exp_out;
      logic       exp_hit;
      logic       exp_borrow;
      int         lat;
   } vec_t;

   typedef struct {
      logic [7:0] out;
      logic       hit;
      logic       borrow;
      string      name;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   int     checks = 0;
   int     failures = 0;
   exp_t   sb[$];
   vec_t   vecs[$];
   logic   prev_done = 1'b0;

   mem_rssb_ram_if #(.WIDTH(8)) bus ();

   mem_rssb_ram #(
      .WIDTH (8),
      .DEPTH (4),
      .INIT  (MEM_INIT_DEFAULT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard: every done pulse pops one expectation
   always @(negedge clk) begin
      if (rst) begin
         prev_done = 1'b0;
      end else begin
         if (bus.done) begin
            check("done_not_consecutive", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got done with empty scoreboard expected none");
            end else begin
               exp_t e;
               e = sb.pop_front();
               check({e.name, "_out"}, {24'd0, bus.out}, {24'd0, e.out});
               check({e.name, "_hit"}, {31'd0, bus.hit}, {31'd0, e.hit});
               check({e.name, "_borrow"}, {31'd0, bus.borrow}, {31'd0, e.borrow});
            end
         end
         prev_done = bus.done;
      end
   end

   task automatic do_op(input op_e o, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] eo, input logic eh, input logic eb,
                        input int lat, input string name);
      int n;
      logic seen;
      @(negedge clk);
      bus.req = 1'b1;
      bus.op = o;
      bus.address = a;
      bus.in = d;
      sb.push_back('{eo, eh, eb, name});
      @(negedge clk);
      bus.req = 1'b0;
      check({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 8) begin
         @(negedge clk);
         n++;
         seen = bus.done;
      end
      check({name, "_latency"}, seen ? n : 99, lat);
   endtask

   initial begin
      int ndone;
      bus.req = 1'b0;
      bus.op = OP_READ;
      bus.address = 8'h00;
      bus.in = 8'h00;

      vecs.push_back('{OP_READ,  8'h80, 8'h00, 8'h01, 1'b1, 1'b0, 1});
      vecs.push_back('{OP_READ,  8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1});
      vecs.push_back('{OP_READ,  8'h82, 8'h00, 8'h08, 1'b1, 1'b0, 1});
      vecs.push_back('{OP_READ,  8'h83, 8'h00, 8'h04, 1'b1, 1'b0, 1});
      vecs.push_back('{OP_WRITE, 8'h82, 8'h55, 8'h04, 1'b1, 1'b0, 1});
      vecs.push_back('{OP_READ,  8'h82, 8'h00, 8'h55, 1'b1, 1'b0, 1});
      vecs.push_back('{OP_READ,  8'h86, 8'h00, 8'h55, 1'b1, 1'b0, 1});
      vecs.push_back('{OP_READ,  8'h83, 8'h00, 8'h04, 1'b1, 1'b0, 1});
      vecs.push_back('{OP_RSSB,  8'h81, 8'h05, 8'hFD, 1'b1, 1'b1, 2});
      vecs.push_back('{OP_READ,  8'h81, 8'h00, 8'hFD, 1'b1, 1'b1, 1});
      vecs.push_back('{OP_RSSB,  8'h80, 8'h01, 8'h00, 1'b1, 1'b0, 2});
      vecs.push_back('{OP_WRITE, 8'h03, 8'hAA, 8'h00, 1'b0, 1'b0, 1});
      vecs.push_back('{OP_READ,  8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 1});
      vecs.push_back('{OP_READ,  8'h81, 8'h00, 8'hFD, 1'b1, 1'b0, 1});
      vecs.push_back('{OP_READ,  8'h82, 8'h00, 8'h55, 1'b1, 1'b0, 1});
      vecs.push_back('{OP_READ,  8'h83, 8'h00, 8'h04, 1'b1, 1'b0, 1});
      vecs.push_back('{op_e'(2'b11), 8'h80, 8'h77, 8'h00, 1'b0, 1'b0, 1});
      vecs.push_back('{OP_READ,  8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 1});
      vecs.push_back('{OP_RSSB,  8'h83, 8'h05, 8'hFF, 1'b1, 1'b1, 2});
      vecs.push_back('{OP_WRITE, 8'h03, 8'hAA, 8'h00, 1'b0, 1'b1, 1});
      vecs.push_back('{OP_READ,  8'h83, 8'h00, 8'hFF, 1'b1, 1'b1, 1});

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_out", {24'd0, bus.out}, 32'd0);
      check("rst_hit", {31'd0, bus.hit}, 32'd0);
      check("rst_borrow", {31'd0, bus.borrow}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         do_op(vecs[i].op, vecs[i].addr, vecs[i].din, vecs[i].exp_out,
               vecs[i].exp_hit, vecs[i].exp_borrow, vecs[i].lat,
               $sformatf("vec%0d", i));
      end

      // requests during an RSSB in flight must be dropped
      @(negedge clk);
      bus.req = 1'b1;
      bus.op = OP_RSSB;
      bus.address = 8'h82;
      bus.in = 8'h10;
      sb.push_back('{8'h45, 1'b1, 1'b0, "rssb_busy_req"});
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.done) ndone++;
         bus.req = (k < 2);
         bus.op = OP_READ;
         bus.address = 8'h80;
      end
      check("busy_req_single_done", ndone, 1);

      // req held high: one READ every second cycle
      for (int k = 0; k < 5; k++) sb.push_back('{8'hFD, 1'b1, 1'b0, $sformatf("b2b%0d", k)});
      @(negedge clk);
      bus.req = 1'b1;
      bus.op = OP_READ;
      bus.address = 8'h81;
      ndone = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.done) ndone++;
         if (k == 9) bus.req = 1'b0;
      end
      check("b2b_done_count", ndone, 5);
      @(negedge clk);
      check("b2b_idle", {31'd0, bus.busy}, 32'd0);

      // reset in EXEC aborts the RSSB and restores the image
      @(negedge clk);
      bus.req = 1'b1;
      bus.op = OP_RSSB;
      bus.address = 8'h82;
      bus.in = 8'h01;
      @(negedge clk);
      bus.req = 1'b0;
      @(negedge clk);
      check("exec_state_busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_no_done", {31'd0, bus.done}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_out", {24'd0, bus.out}, 32'd0);
      check("abort_borrow", {31'd0, bus.borrow}, 32'd0);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      do_op(OP_READ, 8'h82, 8'h00, 8'h08, 1'b1, 1'b0, 1, "post_rst_w2");
      do_op(OP_READ, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1, "post_rst_w1");

      repeat (2) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before timeout");
      $fatal(1, "watchdog");
   end

endmodule
